// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: one-cold row drive, 2-FF column sync, sample-point debounce, key code + strobe.
// Latency: 2 sync cycles + wait for row slot sample + (DEBOUNCE_CNT-1) slots + 1 registered cycle.
// Backpressure: none; key_valid is a single-cycle strobe and key_code holds until the next accepted press.
module keypad_4x4_scanner #(
  parameter logic [31:0] SCAN_CLK     = 32'd100000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // With a single required sample, a press is accepted straight from SCAN
  // and a release straight from PRESSED; no counting state is visited.
  localparam logic ONE_SHOT = (DEBOUNCE_CNT == 8'd1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  col_m;
  logic [3:0]  col_s;
  logic [31:0] slot_cnt;
  logic        sample;

  logic [7:0]  match;
  logic [7:0]  match_nxt;
  logic [7:0]  match_inc;
  logic [3:0]  cand;
  logic [3:0]  cand_nxt;

  logic [3:0]  row_nxt;
  logic [3:0]  row_rot;
  logic [1:0]  row_idx;
  logic [3:0]  code_nxt;
  logic        valid_nxt;
  logic        held_nxt;

  logic        one_low;
  logic [1:0]  col_idx;
  logic [3:0]  cand_pat;

  // Two-flop synchronizer on the raw column pins; idle (all high) out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      col_m <= key_col;
      col_s <= col_m;
    end
  end

  // Free-running row-slot counter; the last count of each slot is the sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= 32'd0;
    end else if (sample) begin
      slot_cnt <= 32'd0;
    end else begin
      slot_cnt <= slot_cnt + 32'd1;
    end
  end

  assign sample    = (slot_cnt == (SCAN_CLK - 32'd1));
  assign row_rot   = {key_row[2:0], key_row[3]};
  assign match_inc = match + 8'd1;

  // Decode which row is currently driven low.
  always_comb begin
    row_idx = 2'd0;
    case (key_row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Detect exactly one closed column; anything else (none, or ghosting/multi-key) is not a candidate.
  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col_s)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Column pattern that confirms the candidate key is still the only one down.
  always_comb begin
    cand_pat = 4'b1111;
    cand_pat[cand[1:0]] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic; everything only moves at a sample point,
  // except key_valid which drops back to zero on every non-accepting cycle.
  always_comb begin
    state_nxt = state;
    match_nxt = match;
    cand_nxt  = cand;
    row_nxt   = key_row;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;

    if (sample) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            cand_nxt = {row_idx, col_idx};
            if (ONE_SHOT) begin
              state_nxt = PRESSED;
              match_nxt = 8'd0;
              code_nxt  = {row_idx, col_idx};
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
              match_nxt = 8'd1;
            end
          end else begin
            row_nxt = row_rot;
          end
        end

        DEBOUNCE: begin
          if (col_s == cand_pat) begin
            if (match_inc == DEBOUNCE_CNT) begin
              state_nxt = PRESSED;
              match_nxt = 8'd0;
              code_nxt  = cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            // Bounce or a different key: give up and move on to the next row.
            state_nxt = SCAN;
            match_nxt = 8'd0;
            row_nxt   = row_rot;
          end
        end

        PRESSED: begin
          // Only a fully open row counts as release; extra keys are ignored.
          if (col_s == 4'b1111) begin
            if (ONE_SHOT) begin
              state_nxt = SCAN;
              match_nxt = 8'd0;
              held_nxt  = 1'b0;
              row_nxt   = row_rot;
            end else begin
              state_nxt = RELEASE;
              match_nxt = 8'd1;
            end
          end
        end

        RELEASE: begin
          if (col_s == 4'b1111) begin
            if (match_inc == DEBOUNCE_CNT) begin
              state_nxt = SCAN;
              match_nxt = 8'd0;
              held_nxt  = 1'b0;
              row_nxt   = row_rot;
            end else begin
              match_nxt = match_inc;
            end
          end else begin
            // Release bounce: still the same physical press, so no new strobe.
            state_nxt = PRESSED;
            match_nxt = 8'd0;
          end
        end

        default: begin
          state_nxt = SCAN;
          match_nxt = 8'd0;
        end
      endcase
    end
  end

  // Registered datapath and outputs so the row pins and strobe are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_row   <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      match     <= 8'd0;
      cand      <= 4'd0;
    end else begin
      key_row   <= row_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
      match     <= match_nxt;
      cand      <= cand_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Bench for keypad_4x4_scanner with SCAN_CLK=4, DEBOUNCE_CNT=3.
// A keypad model closes switches between driven rows and column lines;
// expectations come from key geometry and the scan/debounce timing rules.
module tb_keypad_4x4_scanner;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = 16'h0000;
  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_cnt = 0;

  keypad_4x4_scanner #(
    .SCAN_CLK    (32'd4),
    .DEBOUNCE_CNT(8'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_col  (key_col),
    .key_row  (key_row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed switch at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (key_row[r] === 1'b0)) key_col[c] = 1'b0;
      end
    end
  end

  // Every cycle with key_valid high counts as one strobe.
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_cnt++;
  end

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] v;
    v = 4'b1111;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    keys = 16'h0000;
    repeat (3) tick();
    vectors++; if (key_row !== 4'b1110) begin miscompares++; $display("FAIL reset_row: got %b want 1110", key_row); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL reset_code: got %h want 0", key_code); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", key_held); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Must be entered right after reset is released on a falling edge:
  // after the k-th rising edge the driven row index is (k / SCAN) mod 4.
  task automatic test_idle_scan(input int ncyc);
    int p0;
    logic [3:0] exp;
    p0 = pulse_cnt;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      exp = row_drive((k / SCAN) % 4);
      vectors++;
      if (key_row !== exp) begin
        miscompares++;
        $display("FAIL idle_row cycle %0d: got %b want %b", k, key_row, exp);
      end
    end
    vectors++;
    if (pulse_cnt != p0) begin
      miscompares++;
      $display("FAIL idle_no_valid: got %0d pulses want 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_press_release(input int r, input int c);
    int p0;
    bit seen;
    int ro;
    int co;
    logic [3:0] exp_code;
    exp_code = 4'(r * 4 + c);
    p0 = pulse_cnt;
    keys = 16'h0000;
    keys[r*4+c] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      tick();
      if (key_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL press_timeout r%0d c%0d: got no valid want valid", r, c);
    end else begin
      vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL press_code: got %0d want %0d", key_code, exp_code); end
      vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL press_held: got %b want 1", key_held); end
    end
    // Another key in a different row must not roll over while this one is down.
    ro = (r + 1 + int'($urandom_range(0, 2))) % 4;
    co = int'($urandom_range(0, 3));
    keys[ro*4+co] = 1'b1;
    repeat (40) tick();
    vectors++; if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL press_single_pulse: got %0d want 1", pulse_cnt - p0); end
    vectors++; if (key_row !== row_drive(r)) begin miscompares++; $display("FAIL press_row_frozen: got %b want %b", key_row, row_drive(r)); end
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL hold_held: got %b want 1", key_held); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL hold_code: got %0d want %0d", key_code, exp_code); end
    keys = 16'h0000;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      if (key_held === 1'b0) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL release_timeout: got held=1 want held=0");
    end else begin
      vectors++;
      if (key_row !== row_drive((r + 1) % 4)) begin
        miscompares++;
        $display("FAIL release_row: got %b want %b", key_row, row_drive((r + 1) % 4));
      end
    end
    repeat (8) tick();
    vectors++; if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL release_no_extra: got %0d want 1", pulse_cnt - p0); end
  endtask

  // A closure lasting at most 2*SCAN cycles spans at most 2 sample points: never accepted.
  task automatic test_bounce(input int r, input int c, input int dur);
    int p0;
    logic [3:0] code0;
    p0 = pulse_cnt;
    code0 = key_code;
    repeat (int'($urandom_range(0, 15))) tick();
    keys = 16'h0000;
    keys[r*4+c] = 1'b1;
    repeat (dur) tick();
    keys = 16'h0000;
    repeat (30) tick();
    vectors++; if (pulse_cnt != p0) begin miscompares++; $display("FAIL bounce_valid r%0d c%0d dur %0d: got %0d want 0", r, c, dur, pulse_cnt - p0); end
    vectors++; if (key_code !== code0) begin miscompares++; $display("FAIL bounce_code: got %0d want %0d", key_code, code0); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL bounce_held: got %b want 0", key_held); end
  endtask

  task automatic test_multi_col();
    int p0;
    int r;
    int c1;
    int c2;
    logic [3:0] seen_rows;
    p0 = pulse_cnt;
    r  = int'($urandom_range(0, 3));
    c1 = int'($urandom_range(0, 3));
    c2 = (c1 + 1 + int'($urandom_range(0, 2))) % 4;
    keys = 16'h0000;
    keys[r*4+c1] = 1'b1;
    keys[r*4+c2] = 1'b1;
    seen_rows = 4'b0000;
    repeat (48) begin
      tick();
      seen_rows = seen_rows | ~key_row;
    end
    keys = 16'h0000;
    vectors++; if (seen_rows !== 4'b1111) begin miscompares++; $display("FAIL multi_rows_rotate: got %b want 1111", seen_rows); end
    vectors++; if (pulse_cnt != p0) begin miscompares++; $display("FAIL multi_valid: got %0d want 0", pulse_cnt - p0); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL multi_held: got %b want 0", key_held); end
    repeat (8) tick();
  endtask

  task automatic test_reset_pressed();
    int r;
    int c;
    bit seen;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    keys = 16'h0000;
    keys[r*4+c] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      tick();
      if (key_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstp_press_timeout: got no valid want valid");
    end
    repeat (5) tick();
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL rstp_held_before: got %b want 1", key_held); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (key_row !== 4'b1110) begin miscompares++; $display("FAIL rstp_row: got %b want 1110", key_row); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL rstp_code: got %h want 0", key_code); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rstp_valid: got %b want 0", key_valid); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rstp_held: got %b want 0", key_held); end
    keys = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b1;
    test_idle_scan(16);
  endtask

  initial begin
    test_reset();
    test_idle_scan(32);
    test_press_release(2, 1);
    for (int i = 0; i < 8; i++) begin
      test_press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    test_bounce(0, 3, 8);
    for (int i = 0; i < 8; i++) begin
      test_bounce(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 8)));
    end
    test_multi_col();
    test_multi_col();
    test_reset_pressed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
